// File: rtl/mw_pkg.sv
// rtl/mw_pkg.sv - shared constants for the microwave cook sequencer
// Contents: 2-bit state codes and the all-zero BCD time value.
package mw_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [11:0] BCD_ZERO = 12'h000;

endpackage

// File: rtl/mw_tick_prescaler.sv
// rtl/mw_tick_prescaler.sv - mod-TICK_DIV prescaler producing a one-per-second wrap
// Ports:
//   clk     in  system clock
//   clr     in  asynchronous active-high reset
//   run     in  1 = count this cycle, 0 = hold the current value
//   restart in  force the count to 0 (overrides run)
//   tick    out high in the cycle whose clock edge wraps the count to 0
module mw_tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Combinational so the controller can register its cnt_en in the same
    // edge that wraps the count.
    assign tick = run & ~restart & (count == LAST);

endmodule

// File: rtl/mw_cook_ctrl.sv
// rtl/mw_cook_ctrl.sv - microwave cook sequencer: button arbitration, 1 Hz countdown, magnetron and beep
// Ports:
//   clk, clr            clock and asynchronous active-high reset
//   start, stop         start/resume and stop/pause buttons (acted on at rising edge)
//   clear_btn           clear button (acted on at rising edge)
//   door_closed         1 = door closed
//   keypad_load         1-cycle request to load keypad time into the counter chain
//   time_bcd            current counter-chain value {min, tens, units}
//   cnt_en              1-cycle countdown enable, one per cooked second
//   cnt_loadn, cnt_clrn active-low 1-cycle load / clear strobes to the chain
//   mag_on, beep        magnetron enable and end-of-cook alarm
//   state_o             current state code
module mw_cook_ctrl
    import mw_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int BEEP_TICKS = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic        clear_btn,
    input  logic        door_closed,
    input  logic        keypad_load,
    input  logic [11:0] time_bcd,
    output logic        cnt_en,
    output logic        cnt_loadn,
    output logic        cnt_clrn,
    output logic        mag_on,
    output logic        beep,
    output logic [1:0]  state_o
);

    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    logic [1:0]    state, state_n;
    logic [BW-1:0] beep_cnt, beep_cnt_n;
    logic          start_q, stop_q, clear_q, armed;
    logic          ev_start, ev_stop, ev_clear, zero;
    logic          tick, run, restart;
    logic          cnt_en_n, cnt_loadn_n, cnt_clrn_n, mag_on_n, beep_n;

    // armed stays low for the first clock after reset so that a button
    // already held while clr was asserted is sampled, not taken as a press.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            clear_q <= clear_btn;
            armed   <= 1'b1;
        end
    end

    assign ev_start = armed & start & ~start_q;
    assign ev_stop  = armed & stop & ~stop_q;
    assign ev_clear = armed & clear_btn & ~clear_q;
    assign zero     = (time_bcd == BCD_ZERO);

    mw_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .clr     (clr),
        .run     (run),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_n     = state;
        beep_cnt_n  = beep_cnt;
        cnt_en_n    = 1'b0;
        cnt_loadn_n = 1'b1;
        cnt_clrn_n  = 1'b1;
        mag_on_n    = 1'b0;
        beep_n      = 1'b0;
        run         = 1'b0;
        restart     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev_clear) begin
                    cnt_clrn_n = 1'b0;
                end else begin
                    if (keypad_load) cnt_loadn_n = 1'b0;
                    if (ev_start && door_closed && !zero) begin
                        state_n  = ST_COOK;
                        restart  = 1'b1;
                        mag_on_n = 1'b1;
                    end
                end
            end
            ST_COOK: begin
                if (ev_clear) begin
                    state_n    = ST_IDLE;
                    cnt_clrn_n = 1'b0;
                end else if (!door_closed || ev_stop) begin
                    state_n = ST_PAUSE;
                end else if (zero && !cnt_en) begin
                    // Wait out the cycle where the last cnt_en is applied so
                    // zero reflects the chain after that decrement.
                    state_n    = ST_DONE;
                    beep_n     = 1'b1;
                    restart    = 1'b1;
                    beep_cnt_n = '0;
                end else begin
                    mag_on_n = 1'b1;
                    run      = 1'b1;
                    cnt_en_n = tick & ~zero;
                end
            end
            ST_PAUSE: begin
                if (ev_stop || ev_clear) begin
                    state_n    = ST_IDLE;
                    cnt_clrn_n = 1'b0;
                end else if (ev_start && door_closed) begin
                    // Prescaler is not run on this edge: it resumes from the
                    // exact count it was frozen at.
                    state_n  = ST_COOK;
                    mag_on_n = 1'b1;
                end
            end
            ST_DONE: begin
                if (ev_stop || ev_clear || !door_closed) begin
                    state_n = ST_IDLE;
                end else begin
                    run    = 1'b1;
                    beep_n = 1'b1;
                    if (tick) begin
                        beep_cnt_n = beep_cnt + 1'b1;
                        if (beep_cnt == BEEP_LAST) begin
                            state_n = ST_IDLE;
                            beep_n  = 1'b0;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_IDLE;
            beep_cnt  <= '0;
            cnt_en    <= 1'b0;
            cnt_loadn <= 1'b1;
            cnt_clrn  <= 1'b1;
            mag_on    <= 1'b0;
            beep      <= 1'b0;
        end else begin
            state     <= state_n;
            beep_cnt  <= beep_cnt_n;
            cnt_en    <= cnt_en_n;
            cnt_loadn <= cnt_loadn_n;
            cnt_clrn  <= cnt_clrn_n;
            mag_on    <= mag_on_n;
            beep      <= beep_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mw_cook_ctrl.sv
// tb/tb_mw_cook_ctrl.sv - directed self-checking bench for mw_cook_ctrl with a BCD chain model
module tb_mw_cook_ctrl;

    logic        clk = 1'b0;
    logic        clr, start, stop, clear_btn, door_closed, keypad_load;
    logic [11:0] time_bcd, keypad_val;
    logic        cnt_en, cnt_loadn, cnt_clrn, mag_on, beep;
    logic [1:0]  state_o;
    int          n_cmp = 0;
    int          n_bad = 0;

    mw_cook_ctrl #(.TICK_DIV(4), .BEEP_TICKS(2)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .stop        (stop),
        .clear_btn   (clear_btn),
        .door_closed (door_closed),
        .keypad_load (keypad_load),
        .time_bcd    (time_bcd),
        .cnt_en      (cnt_en),
        .cnt_loadn   (cnt_loadn),
        .cnt_clrn    (cnt_clrn),
        .mag_on      (mag_on),
        .beep        (beep),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] m, t, u;
        {m, t, u} = v;
        if (u != 4'd0) u = u - 4'd1;
        else begin
            u = 4'd9;
            if (t != 4'd0) t = t - 4'd1;
            else begin
                t = 4'd5;
                m = m - 4'd1;
            end
        end
        return {m, t, u};
    endfunction

    always @(posedge clk) begin
        if (!cnt_clrn)      time_bcd <= 12'h000;
        else if (!cnt_loadn) time_bcd <= keypad_val;
        else if (cnt_en)    time_bcd <= bcd_dec(time_bcd);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_time(input logic [11:0] v);
        keypad_val = v;
        keypad_load = 1'b1;
        cyc(1);
        keypad_load = 1'b0;
        n_cmp++; if (cnt_loadn !== 1'b0) begin n_bad++; $display("FAIL load_strobe_low got %b exp 0", cnt_loadn); end
        cyc(1);
        n_cmp++; if (cnt_loadn !== 1'b1) begin n_bad++; $display("FAIL load_strobe_one_cycle got %b exp 1", cnt_loadn); end
    endtask

    task automatic test_reset;
        clr = 1'b1; start = 1'b0; stop = 1'b0; clear_btn = 1'b0;
        door_closed = 1'b1; keypad_load = 1'b0; keypad_val = 12'h000; time_bcd = 12'h000;
        cyc(2);
        clr = 1'b0;
        cyc(2);
        n_cmp++; if ({state_o, cnt_en, cnt_loadn, cnt_clrn, mag_on, beep} !== 7'b00_0_11_00) begin
            n_bad++; $display("FAIL reset_outputs got %b exp 0001100", {state_o, cnt_en, cnt_loadn, cnt_clrn, mag_on, beep});
        end
    endtask

    task automatic test_full_cook;
        int i, en_cnt, en_bad, b;
        load_time(12'h003);
        start = 1'b1; cyc(1); start = 1'b0;
        n_cmp++; if (mag_on !== 1'b1 || state_o !== 2'd1) begin n_bad++; $display("FAIL cook_entry got mag=%b st=%0d exp mag=1 st=1", mag_on, state_o); end
        i = 0; en_cnt = 0; en_bad = 0;
        while (state_o == 2'd1 && i < 40) begin
            cyc(1); i++;
            if (cnt_en === 1'b1) begin
                en_cnt++;
                if (i % 4 != 0 || !cnt_loadn || !cnt_clrn) en_bad++;
            end
        end
        n_cmp++; if (en_cnt != 3) begin n_bad++; $display("FAIL cook_en_count got %0d exp 3", en_cnt); end
        n_cmp++; if (en_bad != 0) begin n_bad++; $display("FAIL cook_en_spacing got %0d misplaced exp 0", en_bad); end
        n_cmp++; if (i != 14 || state_o !== 2'd3) begin n_bad++; $display("FAIL done_entry got cycle %0d st=%0d exp cycle 14 st=3", i, state_o); end
        n_cmp++; if (mag_on !== 1'b0) begin n_bad++; $display("FAIL done_mag got %b exp 0", mag_on); end
        b = 0;
        while (state_o == 2'd3 && b < 20) begin
            if (beep === 1'b1) b++;
            cyc(1);
        end
        n_cmp++; if (b != 8) begin n_bad++; $display("FAIL beep_length got %0d exp 8", b); end
        n_cmp++; if ({state_o, cnt_en, cnt_loadn, cnt_clrn, mag_on, beep} !== 7'b00_0_11_00) begin
            n_bad++; $display("FAIL after_done_outputs got %b exp 0001100", {state_o, cnt_en, cnt_loadn, cnt_clrn, mag_on, beep});
        end
    endtask

    task automatic test_pause_resume;
        int i, en_cnt;
        logic [2:0] en_seq;
        load_time(12'h010);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(6);
        door_closed = 1'b0;
        cyc(1);
        n_cmp++; if (state_o !== 2'd2 || mag_on !== 1'b0) begin n_bad++; $display("FAIL door_pause got st=%0d mag=%b exp st=2 mag=0", state_o, mag_on); end
        n_cmp++; if (time_bcd !== 12'h009) begin n_bad++; $display("FAIL borrow got %h exp 009", time_bcd); end
        en_cnt = 0;
        repeat (5) begin cyc(1); if (cnt_en !== 1'b0) en_cnt++; end
        n_cmp++; if (en_cnt != 0 || state_o !== 2'd2) begin n_bad++; $display("FAIL pause_hold got en=%0d st=%0d exp en=0 st=2", en_cnt, state_o); end
        door_closed = 1'b1;
        cyc(1);
        n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL door_close_no_resume got st=%0d exp 2", state_o); end
        start = 1'b1; cyc(1); start = 1'b0;
        n_cmp++; if (state_o !== 2'd1 || mag_on !== 1'b1) begin n_bad++; $display("FAIL resume got st=%0d mag=%b exp st=1 mag=1", state_o, mag_on); end
        en_seq[2] = cnt_en;
        cyc(1); en_seq[1] = cnt_en;
        cyc(1); en_seq[0] = cnt_en;
        n_cmp++; if (en_seq !== 3'b001) begin n_bad++; $display("FAIL resume_phase got %b exp 001", en_seq); end
        i = 0; en_cnt = 0;
        while (state_o == 2'd1 && i < 60) begin
            cyc(1); i++;
            if (cnt_en === 1'b1) en_cnt++;
        end
        n_cmp++; if (en_cnt != 8 || state_o !== 2'd3) begin n_bad++; $display("FAIL remaining_ticks got %0d st=%0d exp 8 st=3", en_cnt, state_o); end
        i = 0;
        while (state_o != 2'd0 && i < 20) begin cyc(1); i++; end
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL pause_run_end got st=%0d exp 0", state_o); end
    endtask

    task automatic test_stop_start_same;
        load_time(12'h005);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(2);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        n_cmp++; if (state_o !== 2'd2 || mag_on !== 1'b0) begin n_bad++; $display("FAIL stop_wins_cook got st=%0d mag=%b exp st=2 mag=0", state_o, mag_on); end
        cyc(2);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        n_cmp++; if (state_o !== 2'd0 || cnt_clrn !== 1'b0) begin n_bad++; $display("FAIL stop_wins_pause got st=%0d clrn=%b exp st=0 clrn=0", state_o, cnt_clrn); end
        cyc(1);
        n_cmp++; if (cnt_clrn !== 1'b1 || time_bcd !== 12'h000) begin n_bad++; $display("FAIL pause_clear got clrn=%b t=%h exp clrn=1 t=000", cnt_clrn, time_bcd); end
    endtask

    task automatic test_idle_guards;
        start = 1'b1; cyc(1); start = 1'b0;
        n_cmp++; if (state_o !== 2'd0 || mag_on !== 1'b0) begin n_bad++; $display("FAIL zero_start got st=%0d mag=%b exp st=0 mag=0", state_o, mag_on); end
        keypad_val = 12'h123; keypad_load = 1'b1; clear_btn = 1'b1;
        cyc(1);
        keypad_load = 1'b0; clear_btn = 1'b0;
        n_cmp++; if ({cnt_loadn, cnt_clrn} !== 2'b10) begin n_bad++; $display("FAIL clear_over_load got %b exp 10", {cnt_loadn, cnt_clrn}); end
        cyc(1);
        n_cmp++; if (cnt_clrn !== 1'b1 || time_bcd !== 12'h000) begin n_bad++; $display("FAIL clear_over_load_time got clrn=%b t=%h exp clrn=1 t=000", cnt_clrn, time_bcd); end
        load_time(12'h007);
        door_closed = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        n_cmp++; if (state_o !== 2'd0 || mag_on !== 1'b0) begin n_bad++; $display("FAIL door_open_start got st=%0d mag=%b exp st=0 mag=0", state_o, mag_on); end
        door_closed = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset_mid_cook;
        load_time(12'h002);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(2);
        start = 1'b1;
        #2 clr = 1'b1;
        #1;
        n_cmp++; if ({state_o, cnt_en, cnt_loadn, cnt_clrn, mag_on, beep} !== 7'b00_0_11_00) begin
            n_bad++; $display("FAIL async_reset got %b exp 0001100", {state_o, cnt_en, cnt_loadn, cnt_clrn, mag_on, beep});
        end
        @(posedge clk); #1;
        clr = 1'b0;
        cyc(3);
        n_cmp++; if (state_o !== 2'd0 || mag_on !== 1'b0) begin n_bad++; $display("FAIL held_start_after_reset got st=%0d mag=%b exp st=0 mag=0", state_o, mag_on); end
        start = 1'b0;
        cyc(1);
    endtask

    task automatic test_done_stop;
        int i;
        load_time(12'h001);
        start = 1'b1; cyc(1); start = 1'b0;
        i = 0;
        while (state_o != 2'd3 && i < 20) begin cyc(1); i++; end
        n_cmp++; if (state_o !== 2'd3 || i != 6) begin n_bad++; $display("FAIL reach_done got st=%0d cycle %0d exp st=3 cycle 6", state_o, i); end
        cyc(3);
        n_cmp++; if (beep !== 1'b1 || state_o !== 2'd3) begin n_bad++; $display("FAIL done_beep got beep=%b st=%0d exp beep=1 st=3", beep, state_o); end
        stop = 1'b1; cyc(1); stop = 1'b0;
        n_cmp++; if (state_o !== 2'd0 || beep !== 1'b0 || cnt_clrn !== 1'b1) begin
            n_bad++; $display("FAIL done_stop got st=%0d beep=%b clrn=%b exp st=0 beep=0 clrn=1", state_o, beep, cnt_clrn);
        end
        cyc(1);
        n_cmp++; if (cnt_clrn !== 1'b1) begin n_bad++; $display("FAIL done_stop_no_clear got %b exp 1", cnt_clrn); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_full_cook;
        test_pause_resume;
        test_stop_start_same;
        test_idle_guards;
        test_reset_mid_cook;
        test_done_stop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
